// File: rtl/fft_iter_ctrl_if.sv
// Control bundle between the FFT sequencer, the sample source, the
// butterfly/buffer datapath and the bin consumer.
interface fft_iter_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       ld_we;
  logic [3:0] ld_addr;
  logic       bf_issue;
  logic [3:0] bf_addr_a;
  logic [3:0] bf_addr_b;
  logic [2:0] bf_tw_idx;
  logic [1:0] bf_stage;
  logic       wb_we;
  logic [3:0] wb_addr_a;
  logic [3:0] wb_addr_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic       out_last;
  logic       frame_done;

  modport master (
    input  in_valid, out_ready,
    output in_ready, ld_we, ld_addr,
    output bf_issue, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
    output wb_we, wb_addr_a, wb_addr_b,
    output out_valid, out_idx, out_last, frame_done
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, ld_we, ld_addr,
    input  bf_issue, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
    input  wb_we, wb_addr_a, wb_addr_b,
    input  out_valid, out_idx, out_last, frame_done
  );
endinterface

// File: rtl/fft_iter_ctrl.sv
// Sequencer for an in-place iterative 16-point radix-2 DIT FFT: bit-reversed
// load, 4x8 butterfly issues with drain gaps, delayed write-back, bin read-out.
module fft_iter_ctrl #(
  parameter int BF_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  fft_iter_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  localparam logic [3:0] T_LAST = 4'(7 + BF_LAT);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_t, w_t_nxt;
  logic [1:0]  r_stage, w_stage_nxt;
  logic        w_iss;
  logic [3:0]  w_a, w_b;
  logic [2:0]  w_tw;
  logic [8:0]  w_wb;

  function automatic logic [3:0] f_bitrev(input logic [3:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

  // Butterfly k of stage s pairs (k>>s)*2h + (k mod h) with its partner +h.
  function automatic logic [3:0] f_addr_a(input logic [2:0] k, input logic [1:0] s);
    logic [3:0] v_k, v_mask;
    v_k    = {1'b0, k};
    v_mask = (4'd1 << s) - 4'd1;
    return ((v_k >> s) << (3'(s) + 3'd1)) | (v_k & v_mask);
  endfunction

  function automatic logic [2:0] f_tw(input logic [2:0] k, input logic [1:0] s);
    logic [3:0] v_k, v_mask;
    v_k    = {1'b0, k};
    v_mask = (4'd1 << s) - 4'd1;
    return 3'((v_k & v_mask) << (2'd3 - s));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_t     <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_t     <= w_t_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_t_nxt        = r_t;
    w_stage_nxt    = r_stage;
    w_iss          = 1'b0;
    w_a            = '0;
    w_b            = '0;
    w_tw           = '0;
    bus.bf_stage   = '0;
    bus.in_ready   = 1'b0;
    bus.ld_we      = 1'b0;
    bus.ld_addr    = '0;
    bus.out_valid  = 1'b0;
    bus.out_idx    = '0;
    bus.out_last   = 1'b0;
    bus.frame_done = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.ld_we   = 1'b1;
          bus.ld_addr = f_bitrev(r_cnt);
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd15) w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_t < 4'd8) begin
          w_iss        = 1'b1;
          w_a          = f_addr_a(r_t[2:0], r_stage);
          w_b          = w_a + (4'd1 << r_stage);
          w_tw         = f_tw(r_t[2:0], r_stage);
          bus.bf_stage = r_stage;
        end
        // Cycles past t=7 drain the butterfly so the next stage reads fresh data.
        if (r_t == T_LAST) begin
          w_t_nxt     = '0;
          w_stage_nxt = r_stage + 2'd1;
          if (r_stage == 2'd3) w_state_nxt = S_OUT;
        end else begin
          w_t_nxt = r_t + 4'd1;
        end
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = r_cnt;
        bus.out_last  = (r_cnt == 4'd15);
        if (bus.out_ready) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            bus.frame_done = 1'b1;
            w_state_nxt    = S_LOAD;
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign bus.bf_issue  = w_iss;
  assign bus.bf_addr_a = w_a;
  assign bus.bf_addr_b = w_b;
  assign bus.bf_tw_idx = w_tw;

  // Write-back strobe/addresses follow issue by exactly BF_LAT cycles.
  generate
    if (BF_LAT == 0) begin : g_wb_comb
      assign w_wb = {w_iss, w_a, w_b};
    end else begin : g_wb_pipe
      logic [8:0] r_wb_p [BF_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < BF_LAT; i++) r_wb_p[i] <= '0;
        end else begin
          r_wb_p[0] <= {w_iss, w_a, w_b};
          for (int i = 1; i < BF_LAT; i++) r_wb_p[i] <= r_wb_p[i-1];
        end
      end
      assign w_wb = r_wb_p[BF_LAT-1];
    end
  endgenerate

  assign bus.wb_we     = w_wb[8];
  assign bus.wb_addr_a = w_wb[7:4];
  assign bus.wb_addr_b = w_wb[3:0];

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Scoreboard bench for fft_iter_ctrl: BF_LAT=2 main instance plus a BF_LAT=0
// instance sharing the same stimulus.
module tb_fft_iter_ctrl;
  localparam int L = 2;

  typedef struct { int cyc; logic [15:0] d; } ev_t;

  // channels: 0 ld, 1 bf, 2 wb, 3 out accept, 4 lat0 out_valid rise, 5 lat0 issue
  ev_t q [6][$];

  localparam int LD_TAB [16] = '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15};
  localparam int A_TAB [32] = '{0,2,4,6,8,10,12,14,  0,1,4,5,8,9,12,13,
                                0,1,2,3,8,9,10,11,   0,1,2,3,4,5,6,7};
  localparam int B_TAB [32] = '{1,3,5,7,9,11,13,15,  2,3,6,7,10,11,14,15,
                                4,5,6,7,12,13,14,15, 8,9,10,11,12,13,14,15};
  localparam int W_TAB [32] = '{0,0,0,0,0,0,0,0,     0,4,0,4,0,4,0,4,
                                0,2,4,6,0,2,4,6,     0,1,2,3,4,5,6,7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_in_valid = 1'b0;
  logic tb_out_ready = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   calc_start = 0;
  logic prev_ov0 = 1'b0;

  fft_iter_ctrl_if bus2 ();
  fft_iter_ctrl_if bus0 ();

  assign bus2.in_valid  = tb_in_valid;
  assign bus2.out_ready = tb_out_ready;
  assign bus0.in_valid  = tb_in_valid;
  assign bus0.out_ready = tb_out_ready;

  fft_iter_ctrl #(.BF_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus2));
  fft_iter_ctrl #(.BF_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic sb(input int ch, input logic strobe, input logic [15:0] act, input string nm);
    while (q[ch].size() > 0 && q[ch][0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_missing: no event at cycle %0d, required data %0h", nm, q[ch][0].cyc, q[ch][0].d);
      void'(q[ch].pop_front());
    end
    if (strobe === 1'b1) begin
      n_cmp++;
      if (q[ch].size() == 0) begin
        n_bad++;
        $display("FAIL %s_unexpected: got data %0h at cycle %0d, required no event", nm, act, cyc);
      end else if (q[ch][0].cyc != cyc || q[ch][0].d !== act) begin
        n_bad++;
        $display("FAIL %s: got data %0h at cycle %0d, required %0h at cycle %0d",
                 nm, act, cyc, q[ch][0].d, q[ch][0].cyc);
      end
      if (q[ch].size() > 0 && q[ch][0].cyc == cyc) void'(q[ch].pop_front());
    end
  endtask

  // Monitor: compares DUT events against the queued expectations.
  always @(negedge clk) begin
    sb(0, bus2.ld_we, 16'(bus2.ld_addr), "ld");
    sb(1, bus2.bf_issue, 16'({bus2.bf_addr_a, bus2.bf_addr_b, bus2.bf_tw_idx, bus2.bf_stage}), "bf");
    sb(2, bus2.wb_we, 16'({bus2.wb_addr_a, bus2.wb_addr_b}), "wb");
    sb(3, bus2.out_valid & bus2.out_ready, 16'({bus2.out_idx, bus2.out_last, bus2.frame_done}), "out");
    sb(4, bus0.out_valid & ~prev_ov0, 16'(0), "lat0_out_rise");
    sb(5, bus0.bf_issue, 16'(0), "lat0_issue");
    if (!bus2.ld_we) chk("ld_idle", 32'(bus2.ld_addr), 0);
    if (!bus2.bf_issue)
      chk("bf_idle", 32'({bus2.bf_addr_a, bus2.bf_addr_b, bus2.bf_tw_idx, bus2.bf_stage}), 0);
    if (!bus2.wb_we) chk("wb_idle", 32'({bus2.wb_addr_a, bus2.wb_addr_b}), 0);
    if (!(bus2.out_valid && bus2.out_ready)) chk("done_idle", 32'(bus2.frame_done), 0);
    if (!bus2.out_valid) chk("out_idle", 32'({bus2.out_idx, bus2.out_last}), 0);
    if (bus0.bf_issue || bus0.wb_we)
      chk("lat0_wb_eq_issue", 32'({bus0.wb_we, bus0.wb_addr_a, bus0.wb_addr_b}),
          32'({bus0.bf_issue, bus0.bf_addr_a, bus0.bf_addr_b}));
    prev_ov0 <= bus0.out_valid;
  end

  task automatic load_frame(input bit gapped);
    int n = 0;
    bit v = 1'b1;
    chk("in_ready_load", 32'(bus2.in_ready), 1);
    while (n < 16) begin
      tb_in_valid = gapped ? v : 1'b1;
      if (tb_in_valid) begin
        q[0].push_back('{cyc, 16'(LD_TAB[n])});
        n++;
      end
      v = ~v;
      @(posedge clk); #1;
    end
    // Gapped frames keep in_valid high through CALC: it must be ignored.
    tb_in_valid = gapped;
    calc_start = cyc;
    chk("in_ready_drop", 32'(bus2.in_ready), 0);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) begin
        int i = s * 8 + k;
        int c = calc_start + s * (8 + L) + k;
        q[1].push_back('{c, 16'({4'(A_TAB[i]), 4'(B_TAB[i]), 3'(W_TAB[i]), 2'(s)})});
        q[2].push_back('{c + L, 16'({4'(A_TAB[i]), 4'(B_TAB[i])})});
        q[5].push_back('{calc_start + i, 16'(0)});
      end
    q[4].push_back('{calc_start + 32, 16'(0)});
  endtask

  task automatic unload(input int stall_len);
    int ov = calc_start + 4 * (8 + L);
    int idx = 0;
    int st = stall_len;
    while (cyc < ov - 1) begin @(posedge clk); #1; end
    chk("out_valid_before", 32'(bus2.out_valid), 0);
    tb_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("out_valid_rise", 32'(bus2.out_valid), 1);
    while (idx < 16) begin
      if (idx == 3 && st > 0) begin
        tb_out_ready = 1'b0;
        chk("stall_idx_hold", 32'(bus2.out_idx), 3);
        st--;
      end else begin
        tb_out_ready = 1'b1;
        q[3].push_back('{cyc, 16'({4'(idx), idx == 15, idx == 15})});
        idx++;
      end
      @(posedge clk); #1;
    end
    tb_out_ready = 1'b0;
    chk("post_out_valid", 32'(bus2.out_valid), 0);
    chk("post_in_ready", 32'(bus2.in_ready), 1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(bus2.in_ready), 1);
    chk("rst_strobes", 32'({bus2.ld_we, bus2.bf_issue, bus2.wb_we, bus2.out_valid,
                            bus2.out_last, bus2.frame_done}), 0);
    chk("rst_addrs", 32'({bus2.ld_addr, bus2.bf_addr_a, bus2.bf_addr_b, bus2.bf_tw_idx,
                          bus2.bf_stage, bus2.wb_addr_a, bus2.wb_addr_b, bus2.out_idx}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    load_frame(1'b0);
    unload(0);
    repeat (2) begin @(posedge clk); #1; end

    load_frame(1'b1);
    unload(5);
    repeat (2) begin @(posedge clk); #1; end

    // Abort in stage 2 of CALC.
    load_frame(1'b0);
    while (cyc < calc_start + 2 * (8 + L) + 3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    for (int ch = 0; ch < 6; ch++) q[ch].delete();
    chk("abort_strobes", 32'({bus2.ld_we, bus2.bf_issue, bus2.wb_we, bus2.out_valid,
                              bus0.bf_issue, bus0.wb_we}), 0);
    chk("abort_in_ready", 32'(bus2.in_ready), 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    load_frame(1'b0);
    unload(0);
    repeat (3) begin @(posedge clk); #1; end

    for (int ch = 0; ch < 6; ch++) chk($sformatf("queue_drained_%0d", ch), 32'(q[ch].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_iter_ctrl.md
Name: fft_iter_ctrl

Overview:
- Sequencer for a memory-based, iterative 16-point radix-2 DIT FFT.
- One shared butterfly unit (complex multiply by twiddle plus add/subtract, latency BF_LAT) and one 16-entry complex buffer replace the fully unrolled butterfly network.
- The block generates all buffer and butterfly control: bit-reversed sample loading, 4 stages × 8 butterfly issues with twiddle indices, delayed write-back strobes, and a handshaked bin read-out.
- It carries no datapath values; it sits between the FIR output stream and the downstream frequency-analysis logic.

Parameters:
- BF_LAT, 2, butterfly pipeline latency in cycles (legal 0..4); write-back occurs BF_LAT cycles after issue.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  FIR sample available
- in_ready  out  1  controller accepts sample (high only in LOAD)
- ld_we  out  1  buffer write strobe for the incoming sample
- ld_addr  out  4  buffer address for the incoming sample (bit-reversed count)
- bf_issue  out  1  butterfly issue strobe
- bf_addr_a  out  4  upper butterfly operand address
- bf_addr_b  out  4  lower butterfly operand address
- bf_tw_idx  out  3  twiddle index k, W16^k, 0..7
- bf_stage  out  2  stage of the issued butterfly
- wb_we  out  1  butterfly result write-back strobe
- wb_addr_a  out  4  write-back address of result a (= issue addr_a delayed BF_LAT)
- wb_addr_b  out  4  write-back address of result b
- out_valid  out  1  bin available
- out_ready  in  1  consumer accepts bin
- out_idx  out  4  bin index; also the buffer read address
- out_last  out  1  out_valid && out_idx==15
- frame_done  out  1  one-cycle pulse on acceptance of bin 15

Behaviour:
- Reset (async):
  - state = LOAD; all counters = 0.
  - All strobes are 0: ld_we, bf_issue, wb_we, out_valid, out_last, frame_done.
  - All address, index and stage outputs are 0.
  - The write-back delay line is cleared, so no wb_we may appear after reset.
- States: LOAD → CALC → OUT → LOAD.
- LOAD:
  - in_ready = 1.
  - Each in_valid&&in_ready cycle: ld_we = 1 combinationally, ld_addr = bitrev4(cnt); cnt increments.
  - On the 16th acceptance (cnt==15), the next cycle is CALC with cnt = 0.
- CALC:
  - in_ready = 0; in_valid is ignored.
  - Cycle counter t per stage runs 0..(7+BF_LAT).
  - For t<8: bf_issue = 1, with k = t, s = stage, h = 1<<s:
    - bf_addr_a = (k>>s)*2h + (k & (h-1))
    - bf_addr_b = bf_addr_a + h
    - bf_tw_idx = (k & (h-1)) << (3-s)
  - For t ≥ 8: bf_issue = 0; these are drain cycles so stage s+1 never reads stale data.
  - After t = 7+BF_LAT: the stage increments; after stage 3 the state moves to OUT.
- Write-back timing:
  - wb_we / wb_addr_a / wb_addr_b are the issue signals delayed by exactly BF_LAT cycles through a registered pipe.
  - BF_LAT = 0 means combinational pass-through in the same cycle.
- Latency:
  - CALC lasts exactly 4*(8+BF_LAT) cycles.
  - The last wb_we is in the final CALC cycle.
  - out_valid rises in the first cycle after CALC.
- OUT:
  - out_valid = 1; out_idx starts at 0 and advances only on out_valid&&out_ready.
  - With out_ready held low, out_idx is held stable.
  - On acceptance at out_idx==15: frame_done pulses that cycle (combinational on the handshake); the next cycle is LOAD with cnt = 0 and out_valid = 0.
- Outputs when idle: bf_*, wb_*, ld_* and out_* addresses are 0 whenever their strobe is low.
- Rst asserted mid-frame (any state) aborts the frame; partial samples are discarded and the next frame restarts at bitrev(0).

Test Plan:
- Load order: 16 back-to-back in_valid → ld_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; in_ready drops the next cycle.
- Gapped input: in_valid toggled 1,0,1,0… → 16 ld_we only on accepted cycles; CALC entered exactly once.
- Stage 0 and stage 1 issue:
  - Stage 0 k=0..7 → (a,b,tw) = (0,1,0),(2,3,0)…(14,15,0).
  - Stage 1 k=1 → (1,3,4).
  - Stage 3 k=5 → (5,13,5).
  - Stage 2 k=6 → (10,14,4).
- Timing, BF_LAT=2:
  - CALC is 40 cycles; bf_issue idle 2 cycles between stages.
  - wb_we appears 2 cycles after each bf_issue with the same addresses.
  - out_valid rises at cycle 40 after CALC entry.
- Timing, BF_LAT=0:
  - CALC is 32 cycles with no idle gaps.
  - wb_we == bf_issue each cycle.
- Back-pressure: out_ready low for 5 cycles at out_idx=3 → out_idx holds 3; frame_done pulses once, at bin 15 acceptance; the next frame loads normally.
- Reset in CALC stage 2 → all strobes 0 immediately, no later wb_we, in_ready=1, next ld_addr=0.
